// File: rtl/seven_seg_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_ctrl_if
// Requester-side update channel for the seven-segment scan controller.
//   load         : requester asks to update the display; held until load_ack
//   value[15:0]  : four hex nibbles, nibble 0 = rightmost digit
//   dp[3:0]      : decimal point per digit, 1 = on
//   digit_en[3:0]: per-digit enable, 1 = shown
//   load_ack     : one-cycle pulse the cycle after the update was captured
//   pending_full : an accepted update is waiting for the next frame boundary
// Modports: master = requester, slave = controller.
// ---------------------------------------------------------------------------
interface seven_seg_scan_ctrl_if;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  digit_en;
    logic        load_ack;
    logic        pending_full;

    modport master (
        output load, value, dp, digit_en,
        input  load_ack, pending_full
    );

    modport slave (
        input  load, value, dp, digit_en,
        output load_ack, pending_full
    );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_ctrl
// Scan scheduler for a 4-digit common-anode seven-segment display. Each digit
// slot is a BLANK gap (all anodes off) followed by a DRIVE period. Updates
// arrive through a load/ack handshake into a pending buffer that is copied
// into the active register only at the frame boundary, so one frame never
// mixes two values.
//
// Ports:
//   clock      : system clock, rising edge
//   reset      : asynchronous, active-high
//   req        : update channel (seven_seg_scan_ctrl_if.slave)
//   frame_tick : one-cycle pulse during the last DRIVE cycle of digit 3
//   an[3:0]    : anodes, active-low
//   seg[6:0]   : segments g..a, active-low
//   dp_n       : decimal point, active-low
//
// Optional build macro: LEADING_ZERO_BLANK_EN -- when defined, digits 3..1
// are dark while the digit and all higher digits are zero and that digit's
// decimal point is off. Digit 0 is always eligible. Timing is unchanged.
// ---------------------------------------------------------------------------
module seven_seg_scan_ctrl #(
    parameter int DIGIT_TICKS = 12500,
    parameter int BLANK_TICKS = 250
) (
    input  logic                        clock,
    input  logic                        reset,
    seven_seg_scan_ctrl_if.slave        req,
    output logic                        frame_tick,
    output logic [3:0]                  an,
    output logic [6:0]                  seg,
    output logic                        dp_n
);

    localparam int MAX_TICKS = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
    localparam int CW        = $clog2(MAX_TICKS);

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_TICKS - 1);
    localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_TICKS - 1);

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    // Standard hex font, active-low, bit order g,f,e,d,c,b,a.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            4'hF:    s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    // True when digit d is a leading zero with no decimal point of its own.
    function automatic logic lz_suppress(input logic [1:0]  d,
                                         input logic [15:0] v,
                                         input logic [3:0]  p);
        logic r;
        case (d)
            2'd1:    r = (v[15:4]  == 12'h000) && !p[1];
            2'd2:    r = (v[15:8]  == 8'h00)   && !p[2];
            2'd3:    r = (v[15:12] == 4'h0)    && !p[3];
            default: r = 1'b0;
        endcase
        return r;
    endfunction
`endif

    state_t          state_q, state_d;
    logic [1:0]      digit_q, digit_d;
    logic [CW-1:0]   tick_q, tick_d;

    logic [3:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_n_q, dp_n_d;
    logic            frame_tick_q, frame_tick_d;

    logic            load_ack_q, load_ack_d;
    logic            pending_full_q, pending_full_d;
    logic [15:0]     pend_value_q, pend_value_d;
    logic [3:0]      pend_dp_q, pend_dp_d;
    logic [3:0]      pend_en_q, pend_en_d;
    logic [15:0]     act_value_q, act_value_d;
    logic [3:0]      act_dp_q, act_dp_d;
    logic [3:0]      act_en_q, act_en_d;

    logic            xfer_s;
    logic            accept_s;
    logic            show_s;
    logic [3:0]      nib_s;

    // Scan sequencer: BLANK/DRIVE slot timing and digit index.
    always_comb begin
        state_d = state_q;
        digit_d = digit_q;
        tick_d  = tick_q + CW'(1);
        case (state_q)
            ST_BLANK: begin
                if (tick_q == BLANK_LAST) begin
                    state_d = ST_DRIVE;
                    tick_d  = {CW{1'b0}};
                end else begin
                    state_d = ST_BLANK;
                end
            end
            ST_DRIVE: begin
                if (tick_q == DIGIT_LAST) begin
                    state_d = ST_BLANK;
                    tick_d  = {CW{1'b0}};
                    digit_d = digit_q + 2'd1;
                end else begin
                    state_d = ST_DRIVE;
                end
            end
            default: begin
                state_d = ST_BLANK;
                tick_d  = {CW{1'b0}};
                digit_d = 2'd0;
            end
        endcase
    end

    // Display outputs for the state being entered, so pins change on the
    // same edge as the state. Active data never changes on an edge that
    // enters DRIVE, so reading the current active register is safe here.
    always_comb begin
        nib_s  = act_value_q[{digit_d, 2'b00} +: 4];
        show_s = act_en_q[digit_d];
`ifdef LEADING_ZERO_BLANK_EN
        show_s = show_s && !lz_suppress(digit_d, act_value_q, act_dp_q);
`endif
        if ((state_d == ST_DRIVE) && show_s) begin
            an_d   = ~(4'b0001 << digit_d);
            seg_d  = hex_to_seg(nib_s);
            dp_n_d = ~act_dp_q[digit_d];
        end else begin
            an_d   = 4'hF;
            seg_d  = 7'h7F;
            dp_n_d = 1'b1;
        end
        frame_tick_d = (state_d == ST_DRIVE) && (digit_d == 2'd3) && (tick_d == DIGIT_LAST);
    end

    // Handshake and buffers. frame_tick_q marks the frame's last cycle, so
    // the pending->active copy happens on the edge that ends it. A load is
    // refused in an ack cycle so a still-held load is not captured twice.
    always_comb begin
        xfer_s   = frame_tick_q && pending_full_q;
        accept_s = req.load && !load_ack_q && (!pending_full_q || xfer_s);

        if (xfer_s) begin
            act_value_d = pend_value_q;
            act_dp_d    = pend_dp_q;
            act_en_d    = pend_en_q;
        end else begin
            act_value_d = act_value_q;
            act_dp_d    = act_dp_q;
            act_en_d    = act_en_q;
        end

        if (accept_s) begin
            pend_value_d   = req.value;
            pend_dp_d      = req.dp;
            pend_en_d      = req.digit_en;
            pending_full_d = 1'b1;
        end else if (xfer_s) begin
            pend_value_d   = pend_value_q;
            pend_dp_d      = pend_dp_q;
            pend_en_d      = pend_en_q;
            pending_full_d = 1'b0;
        end else begin
            pend_value_d   = pend_value_q;
            pend_dp_d      = pend_dp_q;
            pend_en_d      = pend_en_q;
            pending_full_d = pending_full_q;
        end

        load_ack_d = accept_s;
    end

    // State, buffer and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= ST_BLANK;
            digit_q        <= 2'd0;
            tick_q         <= {CW{1'b0}};
            an_q           <= 4'hF;
            seg_q          <= 7'h7F;
            dp_n_q         <= 1'b1;
            frame_tick_q   <= 1'b0;
            load_ack_q     <= 1'b0;
            pending_full_q <= 1'b0;
            pend_value_q   <= 16'h0000;
            pend_dp_q      <= 4'h0;
            pend_en_q      <= 4'h0;
            act_value_q    <= 16'h0000;
            act_dp_q       <= 4'h0;
            act_en_q       <= 4'h0;
        end else begin
            state_q        <= state_d;
            digit_q        <= digit_d;
            tick_q         <= tick_d;
            an_q           <= an_d;
            seg_q          <= seg_d;
            dp_n_q         <= dp_n_d;
            frame_tick_q   <= frame_tick_d;
            load_ack_q     <= load_ack_d;
            pending_full_q <= pending_full_d;
            pend_value_q   <= pend_value_d;
            pend_dp_q      <= pend_dp_d;
            pend_en_q      <= pend_en_d;
            act_value_q    <= act_value_d;
            act_dp_q       <= act_dp_d;
            act_en_q       <= act_en_d;
        end
    end

    assign an               = an_q;
    assign seg              = seg_q;
    assign dp_n             = dp_n_q;
    assign frame_tick       = frame_tick_q;
    assign req.load_ack     = load_ack_q;
    assign req.pending_full = pending_full_q;

endmodule
